ascon_ti_share_gen: RTL



---
 rtl/ascon_ti_pkg.sv | 21 ++
 rtl/ascon_ti_share_reg.sv | 40 ++++
 rtl/ascon_ti_share_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ascon_ti_pkg.sv
// Shared constants, FSM encoding and state-packing helpers for the Ascon TI share generator.
package ascon_ti_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned N_WORDS = 5;
  localparam int unsigned N_RND   = 2 * N_WORDS;
  localparam int unsigned STATE_W = WORD_W * N_WORDS;
  localparam int unsigned CNT_W   = $clog2(N_RND + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StOut
  } state_e;

  // x0 sits in the most significant word of a packed 320-bit state.
  function automatic int unsigned word_lsb(input int unsigned w);
    return (N_WORDS - 1 - w) * WORD_W;
  endfunction

endpackage

// File: rtl/ascon_ti_share_reg.sv
// One 320-bit share register: full load, per-word write, per-word XOR update, synchronous clear.
module ascon_ti_share_reg
  import ascon_ti_pkg::*;
(
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               ld_i,
  input  logic [STATE_W-1:0] ld_data_i,
  input  logic [N_WORDS-1:0] wr_en_i,
  input  logic [N_WORDS-1:0] xor_en_i,
  input  logic [WORD_W-1:0]  wdata_i,
  output logic [STATE_W-1:0] data_o
);

  logic [STATE_W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (ld_i) begin
      data_d = ld_data_i;
    end else begin
      for (int unsigned w = 0; w < N_WORDS; w++) begin
        if (wr_en_i[w]) begin
          data_d[word_lsb(w) +: WORD_W] = wdata_i;
        end else if (xor_en_i[w]) begin
          data_d[word_lsb(w) +: WORD_W] = data_q[word_lsb(w) +: WORD_W] ^ wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/ascon_ti_share_gen.sv
// Splits one unmasked Ascon state into three TI shares using 10 fresh PRNG beats,
// releasing the shares only when complete and scrubbing them after handoff.
module ascon_ti_share_gen
  import ascon_ti_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_x0,
  input  logic [WORD_W-1:0]  in_x1,
  input  logic [WORD_W-1:0]  in_x2,
  input  logic [WORD_W-1:0]  in_x3,
  input  logic [WORD_W-1:0]  in_x4,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [WORD_W-1:0]  rnd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_share0,
  output logic [STATE_W-1:0] out_share1,
  output logic [STATE_W-1:0] out_share2
);

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               in_ready_d, in_ready_q;
  logic               rnd_ready_d, rnd_ready_q;
  logic               out_valid_d, out_valid_q;

  logic               capture, beat, handoff, second_half;
  logic [CNT_W-1:0]   word_idx;
  logic [N_WORDS-1:0] word_oh;
  logic [STATE_W-1:0] sh0, sh1, sh2;

  // The ready/valid flops are only ever set in their own state, so they double as state decodes.
  assign capture     = in_ready_q & in_valid;
  assign beat        = rnd_ready_q & rnd_valid;
  assign handoff     = out_valid_q & out_ready;
  assign second_half = (cnt_q >= CNT_W'(N_WORDS));
  assign word_idx    = second_half ? (cnt_q - CNT_W'(N_WORDS)) : cnt_q;

  always_comb begin
    word_oh = '0;
    for (int unsigned w = 0; w < N_WORDS; w++) begin
      word_oh[w] = (word_idx == CNT_W'(w));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StCollect;
          cnt_d   = '0;
        end
      end
      StCollect: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_RND - 1)) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (handoff) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d == StIdle);
    rnd_ready_d = (state_d == StCollect);
    out_valid_d = (state_d == StOut);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      rnd_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      rnd_ready_q <= rnd_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Share 0 starts as the plain state and absorbs every beat; shares 1/2 take beats 0-4 / 5-9.
  ascon_ti_share_reg u_sh0 (
    .clk_i     (clk),
    .clr_i     (!rst_n || handoff),
    .ld_i      (capture),
    .ld_data_i ({in_x0, in_x1, in_x2, in_x3, in_x4}),
    .wr_en_i   ('0),
    .xor_en_i  (beat ? word_oh : '0),
    .wdata_i   (rnd_data),
    .data_o    (sh0)
  );

  ascon_ti_share_reg u_sh1 (
    .clk_i     (clk),
    .clr_i     (!rst_n || handoff || capture),
    .ld_i      (1'b0),
    .ld_data_i ('0),
    .wr_en_i   ((beat && !second_half) ? word_oh : '0),
    .xor_en_i  ('0),
    .wdata_i   (rnd_data),
    .data_o    (sh1)
  );

  ascon_ti_share_reg u_sh2 (
    .clk_i     (clk),
    .clr_i     (!rst_n || handoff || capture),
    .ld_i      (1'b0),
    .ld_data_i ('0),
    .wr_en_i   ((beat && second_half) ? word_oh : '0),
    .xor_en_i  ('0),
    .wdata_i   (rnd_data),
    .data_o    (sh2)
  );

  assign in_ready   = in_ready_q;
  assign rnd_ready  = rnd_ready_q;
  assign out_valid  = out_valid_q;
  assign out_share0 = out_valid_q ? sh0 : '0;
  assign out_share1 = out_valid_q ? sh1 : '0;
  assign out_share2 = out_valid_q ? sh2 : '0;

endmodule
